// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core with a single unified memory port and a six-state control FSM.
// Define MULTI_CYCLE_CPU_BNE_EN to add bne (op 5); otherwise op 5 halts the core as an unknown opcode.
module multi_cycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [31:0]       pc_o,
  output logic              retire_o,
  output logic              halt_o
);

  localparam logic [5:0] OP_R = 6'd0, OP_J = 6'd2, OP_BEQ = 6'd4, OP_BNE = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8, OP_SLTI = 6'd10, OP_LW = 6'd35, OP_SW = 6'd43;
  localparam logic [5:0] F_SLL = 6'h00, F_ADD = 6'h20, F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

`ifdef MULTI_CYCLE_CPU_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr, r_target;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_dst;
  logic [31:0] w_imm, w_alu, w_wb_data;
  logic        w_legal, w_is_branch, w_take, w_is_mem, w_misalign;

  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_funct    = r_ir[5:0];
  assign w_imm      = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_dst      = (w_op == OP_R) ? w_rd : w_rt;
  assign w_wb_data  = (w_op == OP_LW) ? r_mdr : r_alu;
  assign w_is_branch = (w_op == OP_BEQ) || (w_op == OP_BNE);
  assign w_take     = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);
  assign w_is_mem   = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_misalign = (w_alu[1:0] != 2'b00);

  // Opcode/funct legality is resolved in DECODE so illegal words never reach EXEC
  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      OP_R: begin
        case (w_funct)
          F_SLL, F_ADD, F_SUB, F_AND, F_OR, F_SLT: w_legal = 1'b1;
          default:                                 w_legal = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: w_legal = 1'b1;
      OP_BNE:                                       w_legal = BNE_EN;
      default:                                      w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_R: begin
        case (w_funct)
          F_ADD:   w_alu = r_a + r_b;
          F_SUB:   w_alu = r_a - r_b;
          F_AND:   w_alu = r_a & r_b;
          F_OR:    w_alu = r_a | r_b;
          F_SLT:   w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
          F_SLL:   w_alu = r_b << r_ir[10:6];
          default: w_alu = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: w_alu = r_a + w_imm;
      OP_SLTI:               w_alu = {31'd0, $signed(r_a) < $signed(w_imm)};
      default:               w_alu = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ack_i) w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (w_is_branch || (w_op == OP_J)) w_next = S_FETCH;
        else if (w_is_mem)                 w_next = w_misalign ? S_HALT : S_MEM;
        else                               w_next = S_WB;
      end
      S_MEM:    if (mem_ack_i) w_next = (w_op == OP_SW) ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_HALT;
    endcase
  end

  // Bus fields come only from registers, so they hold steady across wait states
  always_comb begin
    mem_req_o   = !rst_i && ((r_state == S_FETCH) || (r_state == S_MEM));
    mem_we_o    = (r_state == S_MEM) && (w_op == OP_SW);
    mem_addr_o  = (r_state == S_MEM) ? r_alu[ADDR_W-1:0] : r_pc[ADDR_W-1:0];
    mem_wdata_o = r_b;
    halt_o      = (r_state == S_HALT);
    retire_o    = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_EXEC:  retire_o = w_is_branch || (w_op == OP_J);
        S_MEM:   retire_o = mem_ack_i && (w_op == OP_SW);
        S_WB:    retire_o = 1'b1;
        default: retire_o = 1'b0;
      endcase
    end
  end

  assign pc_o = r_pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_alu    <= '0;
      r_mdr    <= '0;
      r_target <= '0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ack_i) begin
          r_ir <= mem_rdata_i;
          r_pc <= r_pc + 32'd4;
        end
        S_DECODE: begin
          r_a      <= r_rf[w_rs];
          r_b      <= r_rf[w_rt];
          r_target <= r_pc + (w_imm << 2);
        end
        S_EXEC: begin
          r_alu <= w_alu;
          if (w_is_branch && w_take) r_pc <= r_target;
          if (w_op == OP_J)          r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        end
        S_MEM: if (mem_ack_i && (w_op == OP_LW)) r_mdr <= mem_rdata_i;
        S_WB:  if (w_dst != 5'd0) r_rf[w_dst] <= w_wb_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: vector table, directed sequences and random programs checked
// against an instruction-level reference model (bus transactions, latencies, final memory).
module tb_multi_cycle_cpu;
  localparam logic [31:0] RPC = 32'h100;
  localparam logic [31:0] HALT_I = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_req_o, mem_we_o, retire_o, halt_o;
  logic [31:0] mem_addr_o, mem_wdata_o, pc_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  always #5 clk = ~clk;

  multi_cycle_cpu #(.RESET_PC(RPC), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .pc_o(pc_o), .retire_o(retire_o), .halt_o(halt_o));

  typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } bus_t;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] tb_mem [256];
  logic [31:0] m_mem  [256];
  logic [31:0] m_reg  [32];
  logic [31:0] m_pc;
  bit          m_halt;
  bus_t        exp_q[$];
  int          exp_lat[$];
  logic [31:0] rd_log[$];
  int          n_wait, n_ret;
  bit          spur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh);
    return {6'd0, rs, rt, rd, sh, f};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] addr);
    return {6'd2, addr[27:2]};
  endfunction
  function automatic logic [31:0] sx(input logic [15:0] i);
    return {{16{i[15]}}, i};
  endfunction
  function automatic logic [7:0] wi(input logic [31:0] a);
    return a[9:2];
  endfunction

  // Reference model: executes one whole instruction, queuing the bus traffic and latency it implies
  task automatic iss_step();
    logic [31:0] ins, a, b, ea, res;
    logic [4:0]  dst;
    int          nreq, lat;
    bit          wr;
    ins = m_mem[wi(m_pc)];
    exp_q.push_back('{we: 1'b0, addr: m_pc, data: 32'h0});
    m_pc = m_pc + 32'd4;
    a = m_reg[ins[25:21]];
    b = m_reg[ins[20:16]];
    ea = a + sx(ins[15:0]);
    nreq = 1; lat = 4; wr = 1'b1; dst = ins[20:16]; res = ea;
    case (ins[31:26])
      6'd0: begin
        dst = ins[15:11];
        case (ins[5:0])
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: res = b << ins[10:6];
          default: begin m_halt = 1'b1; return; end
        endcase
      end
      6'd8:  res = ea;
      6'd10: res = ($signed(a) < $signed(sx(ins[15:0]))) ? 32'd1 : 32'd0;
      6'd35: begin
        if (ea[1:0] != 2'b00) begin m_halt = 1'b1; return; end
        exp_q.push_back('{we: 1'b0, addr: ea, data: 32'h0});
        res = m_mem[wi(ea)]; nreq = 2; lat = 5;
      end
      6'd43: begin
        if (ea[1:0] != 2'b00) begin m_halt = 1'b1; return; end
        exp_q.push_back('{we: 1'b1, addr: ea, data: b});
        m_mem[wi(ea)] = b; nreq = 2; wr = 1'b0;
      end
      6'd4: begin
        if (a == b) m_pc = m_pc + (sx(ins[15:0]) << 2);
        lat = 3; wr = 1'b0;
      end
`ifdef MULTI_CYCLE_CPU_BNE_EN
      6'd5: begin
        if (a != b) m_pc = m_pc + (sx(ins[15:0]) << 2);
        lat = 3; wr = 1'b0;
      end
`endif
      6'd2: begin
        m_pc = {m_pc[31:28], ins[25:0], 2'b00};
        lat = 3; wr = 1'b0;
      end
      default: begin m_halt = 1'b1; return; end
    endcase
    if (wr && dst != 5'd0) m_reg[dst] = res;
    exp_lat.push_back(lat + n_wait * nreq);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    mem_ack_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("req in reset", {31'd0, mem_req_o}, 32'd0);
    check("reset pc", pc_o, RPC);
    check("reset halt/retire", {30'd0, halt_o, retire_o}, 32'd0);
    rst_i = 1'b0;
    mem_ack_i = 1'b0;
    #1;
  endtask

  task automatic run_prog(input string name, input int max_cyc);
    int          since, wcnt;
    bit          stall, done, quiet;
    logic [31:0] pa, pd;
    logic        pw;
    bus_t        e;
    for (int i = 0; i < 256; i++) m_mem[i] = tb_mem[i];
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_pc = RPC; m_halt = 1'b0;
    exp_q.delete(); exp_lat.delete(); rd_log.delete();
    for (int i = 0; i < 500 && !m_halt; i++) iss_step();
    do_reset();
    since = 0; wcnt = 0; stall = 0; done = 0; n_ret = 0;
    pa = '0; pd = '0; pw = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      mem_ack_i   = mem_req_o ? (wcnt >= n_wait) : (spur && $urandom_range(0, 3) == 0);
      mem_rdata_i = tb_mem[wi(mem_addr_o)];
      #1;
      since++;
      if (stall && mem_req_o)
        check({name, " held bus"}, {mem_we_o, mem_addr_o[30:0]} ^ mem_wdata_o, {pw, pa[30:0]} ^ pd);
      if (mem_req_o && mem_ack_i) begin
        if (exp_q.size() == 0) check({name, " extra request"}, mem_addr_o, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check({name, " bus addr"}, mem_addr_o, e.addr);
          check({name, " bus we"}, {31'd0, mem_we_o}, {31'd0, e.we});
          if (e.we) check({name, " bus wdata"}, mem_wdata_o, e.data);
        end
        if (mem_we_o) tb_mem[wi(mem_addr_o)] = mem_wdata_o;
        else          rd_log.push_back(mem_addr_o);
        wcnt = 0; stall = 0;
      end else if (mem_req_o) begin
        wcnt++; stall = 1; pa = mem_addr_o; pd = mem_wdata_o; pw = mem_we_o;
      end else stall = 0;
      if (retire_o) begin
        n_ret++;
        if (exp_lat.size() == 0) check({name, " extra retire"}, 32'd1, 32'd0);
        else check({name, " latency"}, 32'(since), 32'(exp_lat.pop_front()));
        since = 0;
      end
      if (halt_o) done = 1;
      else @(negedge clk);
    end
    check({name, " halted"}, {31'd0, halt_o}, {31'd0, m_halt});
    check({name, " bus left"}, 32'(exp_q.size()), 32'd0);
    check({name, " retires left"}, 32'(exp_lat.size()), 32'd0);
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack_i = 1'b1;
      #1;
      if (mem_req_o || retire_o || !halt_o) quiet = 0;
    end
    mem_ack_i = 1'b0;
    check({name, " quiet in halt"}, {31'd0, quiet}, 32'd1);
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [5:0] fl [6];
    logic [4:0] s, t, d;
    int         k;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 10);
    case (k)
      0, 1, 2, 3, 4, 5: return enc_r(fl[k], s, t, d, 5'($urandom_range(0, 31)));
      6: return enc_i(6'd8, s, t, 16'($urandom));
      7: return enc_i(6'd10, s, t, 16'($urandom));
      8: return enc_i(6'd35, 5'd0, t, 16'(32'h200 + 4 * $urandom_range(0, 63)));
      9: return enc_i(6'd43, 5'd0, t, 16'(32'h200 + 4 * $urandom_range(0, 63)));
      default: return enc_i(6'd4, s, t, 16'($urandom_range(0, 2)));
    endcase
  endfunction

  typedef struct { logic [31:0] ins; logic [15:0] a; logic [15:0] b; logic [4:0] sreg; logic [31:0] exp; } vec_t;
  vec_t vt [13];

  initial begin
    vt[0]  = '{enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 16'd5, 16'hFFFD, 5'd3, 32'd2};
    vt[1]  = '{enc_r(6'h22, 5'd1, 5'd2, 5'd3, 5'd0), 16'd5, 16'hFFFD, 5'd3, 32'd8};
    vt[2]  = '{enc_r(6'h22, 5'd2, 5'd1, 5'd3, 5'd0), 16'd5, 16'hFFFD, 5'd3, 32'hFFFF_FFF8};
    vt[3]  = '{enc_r(6'h24, 5'd1, 5'd2, 5'd3, 5'd0), 16'h00F0, 16'h0FF0, 5'd3, 32'h0000_00F0};
    vt[4]  = '{enc_r(6'h25, 5'd1, 5'd2, 5'd3, 5'd0), 16'h00F0, 16'h0F0F, 5'd3, 32'h0000_0FFF};
    vt[5]  = '{enc_r(6'h2A, 5'd2, 5'd1, 5'd3, 5'd0), 16'd5, 16'hFFFD, 5'd3, 32'd1};
    vt[6]  = '{enc_r(6'h2A, 5'd1, 5'd2, 5'd3, 5'd0), 16'd5, 16'hFFFD, 5'd3, 32'd0};
    vt[7]  = '{enc_r(6'h00, 5'd0, 5'd2, 5'd3, 5'd4), 16'd5, 16'hFFFD, 5'd3, 32'hFFFF_FFD0};
    vt[8]  = '{enc_i(6'd8, 5'd1, 5'd3, 16'hFFF6), 16'd5, 16'hFFFD, 5'd3, 32'hFFFF_FFFB};
    vt[9]  = '{enc_i(6'd10, 5'd2, 5'd3, 16'h0000), 16'd5, 16'hFFFD, 5'd3, 32'd1};
    vt[10] = '{enc_i(6'd10, 5'd1, 5'd3, 16'hFFFF), 16'd5, 16'hFFFD, 5'd3, 32'd0};
    vt[11] = '{enc_r(6'h20, 5'd1, 5'd2, 5'd0, 5'd0), 16'd5, 16'hFFFD, 5'd0, 32'd0};
    vt[12] = '{enc_r(6'h00, 5'd0, 5'd2, 5'd3, 5'd31), 16'd5, 16'd3, 5'd3, 32'h8000_0000};
    spur = 0;

    for (int v = 0; v < 13; v++) begin
      clear_mem();
      tb_mem[wi(32'h300)] = 32'hA5A5_A5A5;
      tb_mem[wi(RPC)]      = enc_i(6'd8, 5'd0, 5'd1, vt[v].a);
      tb_mem[wi(RPC + 4)]  = enc_i(6'd8, 5'd0, 5'd2, vt[v].b);
      tb_mem[wi(RPC + 8)]  = vt[v].ins;
      tb_mem[wi(RPC + 12)] = enc_i(6'd43, 5'd0, vt[v].sreg, 16'h0300);
      tb_mem[wi(RPC + 16)] = HALT_I;
      n_wait = v % 2;
      run_prog($sformatf("vec%0d", v), 200);
      check($sformatf("vec%0d result", v), tb_mem[wi(32'h300)], vt[v].exp);
    end

    // Registers must be zero straight after reset, even though earlier programs wrote them
    clear_mem();
    tb_mem[wi(32'h300)] = 32'h1234_5678;
    tb_mem[wi(32'h304)] = 32'h1234_5678;
    tb_mem[wi(RPC)]     = enc_i(6'd43, 5'd0, 5'd2, 16'h0300);
    tb_mem[wi(RPC + 4)] = enc_i(6'd43, 5'd0, 5'd1, 16'h0304);
    tb_mem[wi(RPC + 8)] = HALT_I;
    n_wait = 0;
    run_prog("regs zero", 100);
    check("first fetch addr", rd_log[0], RPC);
    check("r2 after reset", tb_mem[wi(32'h300)], 32'd0);
    check("r1 after reset", tb_mem[wi(32'h304)], 32'd0);

    clear_mem();
    tb_mem[wi(RPC)]      = enc_i(6'd8, 5'd0, 5'd1, 16'd5);
    tb_mem[wi(RPC + 4)]  = enc_i(6'd8, 5'd0, 5'd2, 16'hFFFD);
    tb_mem[wi(RPC + 8)]  = enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
    tb_mem[wi(RPC + 12)] = enc_r(6'h2A, 5'd2, 5'd1, 5'd4, 5'd0);
    tb_mem[wi(RPC + 16)] = enc_i(6'd43, 5'd0, 5'd3, 16'h0300);
    tb_mem[wi(RPC + 20)] = enc_i(6'd43, 5'd0, 5'd4, 16'h0304);
    tb_mem[wi(RPC + 24)] = HALT_I;
    run_prog("alu seq", 200);
    check("alu seq r3", tb_mem[wi(32'h300)], 32'd2);
    check("alu seq r4", tb_mem[wi(32'h304)], 32'd1);

    clear_mem();
    tb_mem[wi(RPC)]      = enc_i(6'd8, 5'd0, 5'd1, 16'd5);
    tb_mem[wi(RPC + 4)]  = enc_i(6'd43, 5'd0, 5'd1, 16'h0008);
    tb_mem[wi(RPC + 8)]  = enc_i(6'd35, 5'd0, 5'd5, 16'h0008);
    tb_mem[wi(RPC + 12)] = enc_i(6'd43, 5'd0, 5'd5, 16'h0300);
    tb_mem[wi(RPC + 16)] = HALT_I;
    n_wait = 3;
    run_prog("wait mem", 300);
    check("wait mem 0x8", tb_mem[wi(32'h8)], 32'd5);
    check("wait mem r5", tb_mem[wi(32'h300)], 32'd5);

    clear_mem();
    tb_mem[wi(RPC)]      = enc_i(6'd8, 5'd0, 5'd1, 16'd7);
    tb_mem[wi(RPC + 4)]  = enc_j(32'h44);
    tb_mem[wi(32'h44)]   = enc_i(6'd4, 5'd1, 5'd1, 16'hFFFE);
    tb_mem[wi(32'h40)]   = enc_j(32'h80);
    tb_mem[wi(32'h80)]   = enc_i(6'd4, 5'd1, 5'd0, 16'd5);
    tb_mem[wi(32'h84)]   = enc_i(6'd43, 5'd0, 5'd1, 16'h0300);
    tb_mem[wi(32'h88)]   = HALT_I;
    n_wait = 0;
    run_prog("branch", 200);
    begin
      logic [31:0] pcs [7];
      pcs = '{RPC, RPC + 4, 32'h44, 32'h40, 32'h80, 32'h84, 32'h88};
      check("branch fetch count", 32'(rd_log.size()), 32'd7);
      for (int i = 0; i < 7 && i < rd_log.size(); i++) check($sformatf("branch pc%0d", i), rd_log[i], pcs[i]);
    end
    check("branch retires", 32'(n_ret), 32'd6);
    check("branch store", tb_mem[wi(32'h300)], 32'd7);

    clear_mem();
    tb_mem[wi(RPC)]     = enc_i(6'd8, 5'd0, 5'd1, 16'd9);
    tb_mem[wi(RPC + 4)] = enc_i(6'd35, 5'd0, 5'd2, 16'h0006);
    run_prog("lw misalign", 100);
    check("lw misalign retires", 32'(n_ret), 32'd1);
    check("lw misalign reads", 32'(rd_log.size()), 32'd2);

    clear_mem();
    tb_mem[wi(RPC)]     = enc_i(6'd8, 5'd0, 5'd1, 16'd9);
    tb_mem[wi(RPC + 4)] = enc_i(6'd43, 5'd0, 5'd1, 16'h0302);
    run_prog("sw misalign", 100);
    check("sw misalign mem", tb_mem[wi(32'h300)], 32'd0);

    clear_mem();
    tb_mem[wi(RPC)] = HALT_I;
    run_prog("bad op", 100);
    check("bad op retires", 32'(n_ret), 32'd0);

    clear_mem();
    tb_mem[wi(RPC)]     = enc_r(6'h3F, 5'd0, 5'd0, 5'd1, 5'd0);
    run_prog("bad funct", 100);
    check("bad funct retires", 32'(n_ret), 32'd0);

    clear_mem();
    tb_mem[wi(RPC)]      = enc_i(6'd8, 5'd0, 5'd1, 16'd1);
    tb_mem[wi(RPC + 4)]  = enc_i(6'd5, 5'd1, 5'd0, 16'd1);
    tb_mem[wi(RPC + 8)]  = enc_i(6'd43, 5'd0, 5'd1, 16'h0300);
    tb_mem[wi(RPC + 12)] = enc_i(6'd43, 5'd0, 5'd1, 16'h0304);
    tb_mem[wi(RPC + 16)] = HALT_I;
    run_prog("bne", 100);
`ifdef MULTI_CYCLE_CPU_BNE_EN
    check("bne skipped", tb_mem[wi(32'h300)], 32'd0);
    check("bne target", tb_mem[wi(32'h304)], 32'd1);
`else
    check("bne halts", 32'(n_ret), 32'd1);
    check("bne no store", tb_mem[wi(32'h304)], 32'd0);
`endif

    // Reset asserted while a fetch is stalled, with a late ack arriving during reset
    clear_mem();
    tb_mem[wi(RPC)]     = enc_i(6'd8, 5'd0, 5'd1, 16'd5);
    tb_mem[wi(RPC + 4)] = HALT_I;
    do_reset();
    @(negedge clk); @(negedge clk); #1;
    check("stalled req", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b1; mem_ack_i = 1'b1; #1;
    check("req dropped in reset", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk); #1;
    check("pc after mid reset", pc_o, RPC);
    mem_ack_i = 1'b0;
    run_prog("after mid reset", 100);

    spur = 1;
    for (int r = 0; r < 6; r++) begin
      logic [31:0] a;
      clear_mem();
      for (int i = 0; i < 64; i++) tb_mem[wi(32'h200) + 8'(i)] = $urandom;
      a = RPC;
      for (int i = 1; i < 8; i++) begin tb_mem[wi(a)] = enc_i(6'd8, 5'd0, 5'(i), 16'($urandom)); a += 4; end
      for (int i = 0; i < 16; i++) begin tb_mem[wi(a)] = rnd_ins(); a += 4; end
      for (int i = 1; i < 8; i++) begin tb_mem[wi(a)] = enc_i(6'd43, 5'd0, 5'(i), 16'(32'h2FC + 4 * i)); a += 4; end
      tb_mem[wi(a)] = HALT_I;
      n_wait = $urandom_range(0, 2);
      run_prog($sformatf("rand%0d", r), 2000);
      for (int i = 0; i < 256; i++) if (tb_mem[i] !== m_mem[i]) check($sformatf("rand%0d mem", r), tb_mem[i], m_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
